// File: rtl/ac_alu_mc_if.sv
// ac_alu_mc_if: bus/control bundle between the control unit and the AC/ALU.
//   Build option: none (the ALU_OVF_EN option lives in ac_alu_mc).
//   Ports carried:
//     ac_control  [1:0]   [0] AC source (0 bus, 1 ALU), [1] AC write request
//     alu_control [2:0]   0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHL, 6/7 PASS bus
//     bus_to_ac   DATA_W  bus operand
//     inst_to_alu CONST_W immediate operand / shift amount
//     ac_to_bus   DATA_W  accumulator contents
//     z_flag, busy, done, div_by_zero, ovf   status back to control/branch logic
//   Modports: master = control unit side, slave = ALU side.
interface ac_alu_mc_if #(
  parameter int DATA_W  = 16,
  parameter int CONST_W = 7
);
  logic [1:0]         ac_control;
  logic [2:0]         alu_control;
  logic [DATA_W-1:0]  bus_to_ac;
  logic [CONST_W-1:0] inst_to_alu;
  logic [DATA_W-1:0]  ac_to_bus;
  logic               z_flag;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic               ovf;

  modport master (
    output ac_control, alu_control, bus_to_ac, inst_to_alu,
    input  ac_to_bus, z_flag, busy, done, div_by_zero, ovf
  );

  modport slave (
    input  ac_control, alu_control, bus_to_ac, inst_to_alu,
    output ac_to_bus, z_flag, busy, done, div_by_zero, ovf
  );
endinterface

// File: rtl/ac_alu_mc.sv
// ac_alu_mc: accumulator + ALU for the downsampling datapath.
//   ADD/SUB/SHR/SHL/PASS and bus loads complete at the accepting edge.
//   MUL (shift-add) and DIV (restoring) iterate one bit per clock with a
//   busy/done handshake; busy is high for exactly DATA_W cycles.
//   Ports:
//     clk    in  clock, all state on posedge
//     rst_n  in  asynchronous active-low reset
//     io     ac_alu_mc_if.slave (control, operands, ac_to_bus and status flags)
//   Build option: define ALU_OVF_EN to build the overflow indicator
//     (ADD carry, SUB borrow, MUL upper product bits, bits shifted out);
//     otherwise ovf is tied to 0 and no carry/upper-product logic exists.
module ac_alu_mc #(
  parameter int DATA_W  = 16,
  parameter int CONST_W = 7,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input logic        clk,
  input logic        rst_n,
  ac_alu_mc_if.slave io
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;

  localparam int CNT_W = $clog2(DATA_W);

  // Product register width: the full double-width product is only needed
  // when overflow detection looks at the upper half.
`ifdef ALU_OVF_EN
  localparam int PW = 2 * DATA_W;
`else
  localparam int PW = DATA_W;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [DATA_W-1:0]  ac;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic [PW-1:0]      a_reg;   // multiplicand (shifts left) or dividend/quotient
  logic [DATA_W-1:0]  b_reg;   // multiplier (shifts right) or divisor
  logic [PW-1:0]      p_reg;   // partial product or partial remainder

  logic [DATA_W-1:0]  b_op;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_mul_req;
  logic               is_div_req;
  logic [DATA_W-1:0]  alu_result;

  logic [PW-1:0]      mul_sum;
  logic [DATA_W:0]    rem_sh;
  logic               div_ge;
  logic [DATA_W-1:0]  rem_next;
  logic [DATA_W-1:0]  quo_next;

  assign b_op       = io.bus_to_ac + DATA_W'(io.inst_to_alu);
  assign shamt      = io.inst_to_alu[SHAMT_W-1:0];
  assign accept     = io.ac_control[1] && (state == IDLE);
  assign is_mul_req = io.ac_control[0] && (io.alu_control == OP_MUL);
  assign is_div_req = io.ac_control[0] && (io.alu_control == OP_DIV);

  always_comb begin
    alu_result = io.bus_to_ac;
    case (io.alu_control)
      OP_ADD:  alu_result = ac + b_op;
      OP_SUB:  alu_result = ac - b_op;
      OP_SHR:  alu_result = io.bus_to_ac >> shamt;
      OP_SHL:  alu_result = io.bus_to_ac << shamt;
      default: alu_result = io.bus_to_ac;
    endcase
  end

  // One iteration of each algorithm; the last iteration's values are also
  // the final result, so ac is written straight from them.
  always_comb begin
    mul_sum  = p_reg + (b_reg[0] ? a_reg : '0);
    rem_sh   = {p_reg[DATA_W-1:0], a_reg[DATA_W-1]};
    div_ge   = rem_sh >= {1'b0, b_reg};
    rem_next = div_ge ? DATA_W'(rem_sh - {1'b0, b_reg}) : rem_sh[DATA_W-1:0];
    quo_next = {a_reg[DATA_W-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ac     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      p_reg  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dbz_q <= 1'b0;
            if (!io.ac_control[0]) begin
              ac <= io.bus_to_ac;
            end else if (is_div_req && (b_op == '0)) begin
              ac     <= '1;
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else if (is_mul_req || is_div_req) begin
              a_reg  <= PW'(ac);
              b_reg  <= b_op;
              p_reg  <= '0;
              is_div <= is_div_req;
              cnt    <= CNT_W'(DATA_W - 1);
              busy_q <= 1'b1;
              state  <= RUN;
            end else begin
              ac <= alu_result;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            p_reg <= PW'(rem_next);
            a_reg <= PW'(quo_next);
          end else begin
            p_reg <= mul_sum;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
          end
          if (cnt == '0) begin
            ac     <= is_div ? quo_next : mul_sum[DATA_W-1:0];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic alu_ovf;
  logic ovf_q;

  // Shift overflow means a 1 left the word: mask out the bits that survive.
  always_comb begin
    alu_ovf = 1'b0;
    if (io.ac_control[0]) begin
      case (io.alu_control)
        OP_ADD:  alu_ovf = alu_result < ac;
        OP_SUB:  alu_ovf = ac < b_op;
        OP_SHR:  alu_ovf = |(io.bus_to_ac & ~({DATA_W{1'b1}} << shamt));
        OP_SHL:  alu_ovf = |(io.bus_to_ac & ~({DATA_W{1'b1}} >> shamt));
        default: alu_ovf = 1'b0;
      endcase
    end
  end

  // MUL leaves ovf alone at acceptance so that ovf and ac change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept && !is_mul_req) begin
      ovf_q <= alu_ovf;
    end else if ((state == RUN) && (cnt == '0)) begin
      ovf_q <= is_div ? 1'b0 : |mul_sum[PW-1:DATA_W];
    end
  end

  assign io.ovf = ovf_q;
`else
  assign io.ovf = 1'b0;
`endif

  assign io.ac_to_bus   = ac;
  assign io.z_flag      = (ac == '0);
  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ac_alu_mc.sv
// tb_ac_alu_mc: directed bench for ac_alu_mc (DATA_W=16, CONST_W=7).
//   Table of single-cycle vectors chained through the accumulator, then
//   hand-written MUL / DIV / div-by-zero / reset-mid-run sequences.
//   Expected ovf follows ALU_OVF_EN when the bench is built with it.
module tb_ac_alu_mc;

`ifdef ALU_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  ac_alu_mc_if #(.DATA_W(16), .CONST_W(7)) dut_if ();

  ac_alu_mc #(.DATA_W(16), .CONST_W(7)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  ctl;
    logic [2:0]  op;
    logic [15:0] bus;
    logic [6:0]  imm;
    logic [15:0] exp_ac;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic applyStimulus(input logic [1:0] ctl, input logic [2:0] op,
                               input logic [15:0] bus, input logic [6:0] imm);
    @(negedge clk);
    dut_if.ac_control  = ctl;
    dut_if.alu_control = op;
    dut_if.bus_to_ac   = bus;
    dut_if.inst_to_alu = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    dut_if.ac_control  = 2'b00;
    dut_if.alu_control = 3'd0;
    dut_if.bus_to_ac   = 16'h0000;
    dut_if.inst_to_alu = 7'd0;
  endtask

  // Counts cycles with busy=1 starting right after the accepting edge.
  task automatic countBusy(output int cycles);
    cycles = 0;
    while (dut_if.busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    checks = 0;
    fails  = 0;

    vecs[0]  = '{"load100",   2'b10, 3'd0, 16'd100,  7'd0,    16'd100,  1'b0};
    vecs[1]  = '{"add",       2'b11, 3'd0, 16'd20,   7'd5,    16'd125,  1'b0};
    vecs[2]  = '{"sub_borrow",2'b11, 3'd1, 16'd200,  7'd0,    16'hFFB5, 1'b1};
    vecs[3]  = '{"loadFFFF",  2'b10, 3'd0, 16'hFFFF, 7'd0,    16'hFFFF, 1'b0};
    vecs[4]  = '{"add_wrap",  2'b11, 3'd0, 16'h0001, 7'd0,    16'h0000, 1'b1};
    vecs[5]  = '{"shr15",     2'b11, 3'd4, 16'h8001, 7'd15,   16'h0001, 1'b1};
    vecs[6]  = '{"shl1",      2'b11, 3'd5, 16'h8001, 7'd1,    16'h0002, 1'b1};
    vecs[7]  = '{"shl_shamt", 2'b11, 3'd5, 16'h0001, 7'h13,   16'h0008, 1'b0};
    vecs[8]  = '{"pass6",     2'b11, 3'd6, 16'h1234, 7'd9,    16'h1234, 1'b0};
    vecs[9]  = '{"add_imm",   2'b11, 3'd0, 16'h0010, 7'h7F,   16'h12C3, 1'b0};
    vecs[10] = '{"no_write",  2'b01, 3'd0, 16'h5555, 7'd0,    16'h12C3, 1'b0};
    vecs[11] = '{"pass7",     2'b11, 3'd7, 16'h0000, 7'd0,    16'h0000, 1'b0};
    vecs[12] = '{"shr4",      2'b11, 3'd4, 16'h00F0, 7'd4,    16'h000F, 1'b0};

    // Reset state
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ac",   32'(dut_if.ac_to_bus),   32'h0);
    checkOutput("rst_z",    32'(dut_if.z_flag),      32'h1);
    checkOutput("rst_busy", 32'(dut_if.busy),        32'h0);
    checkOutput("rst_done", 32'(dut_if.done),        32'h0);
    checkOutput("rst_dbz",  32'(dut_if.div_by_zero), 32'h0);
    checkOutput("rst_ovf",  32'(dut_if.ovf),         32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].op, vecs[i].bus, vecs[i].imm);
      checkOutput({vecs[i].name, "_ac"},   32'(dut_if.ac_to_bus), 32'(vecs[i].exp_ac));
      checkOutput({vecs[i].name, "_z"},    32'(dut_if.z_flag),    32'(vecs[i].exp_ac == 16'h0));
      checkOutput({vecs[i].name, "_ovf"},  32'(dut_if.ovf),       32'(vecs[i].exp_ovf & OVF_EN));
      checkOutput({vecs[i].name, "_busy"}, 32'(dut_if.busy),      32'h0);
      checkOutput({vecs[i].name, "_done"}, 32'(dut_if.done),      32'h0);
    end

    // MUL 300 * 7, with a bus-load request held during busy
    applyStimulus(2'b10, 3'd0, 16'd300, 7'd0);
    applyStimulus(2'b11, 3'd2, 16'd0, 7'd7);
    dut_if.ac_control = 2'b10;
    dut_if.bus_to_ac  = 16'hAAAA;
    checkOutput("mul_busy_start", 32'(dut_if.busy), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mul_ac_hold", 32'(dut_if.ac_to_bus), 32'd300);
    countBusy(cyc);
    checkOutput("mul_busy_len", 32'(cyc + 5), 32'd16);
    checkOutput("mul_ac",   32'(dut_if.ac_to_bus), 32'd2100);
    checkOutput("mul_done", 32'(dut_if.done),      32'h1);
    checkOutput("mul_ovf",  32'(dut_if.ovf),       32'h0);
    @(posedge clk);
    #1;
    checkOutput("mul_done_pulse", 32'(dut_if.done),      32'h0);
    checkOutput("accept_in_done", 32'(dut_if.ac_to_bus), 32'hAAAA);

    // DIV 1000 / 33
    applyStimulus(2'b10, 3'd0, 16'd1000, 7'd0);
    applyStimulus(2'b11, 3'd3, 16'd30, 7'd3);
    idleInputs();
    countBusy(cyc);
    checkOutput("div_busy_len", 32'(cyc), 32'd16);
    checkOutput("div_ac",   32'(dut_if.ac_to_bus),   32'd30);
    checkOutput("div_done", 32'(dut_if.done),        32'h1);
    checkOutput("div_dbz",  32'(dut_if.div_by_zero), 32'h0);

    // DIV by zero: immediate, busy never rises
    applyStimulus(2'b11, 3'd3, 16'd0, 7'd0);
    idleInputs();
    checkOutput("dbz_ac",   32'(dut_if.ac_to_bus),   32'hFFFF);
    checkOutput("dbz_flag", 32'(dut_if.div_by_zero), 32'h1);
    checkOutput("dbz_done", 32'(dut_if.done),        32'h1);
    checkOutput("dbz_busy", 32'(dut_if.busy),        32'h0);
    @(posedge clk);
    #1;
    checkOutput("dbz_done_pulse", 32'(dut_if.done),        32'h0);
    checkOutput("dbz_sticky",     32'(dut_if.div_by_zero), 32'h1);
    applyStimulus(2'b10, 3'd0, 16'd5, 7'd0);
    checkOutput("dbz_cleared", 32'(dut_if.div_by_zero), 32'h0);

    // MUL with a lost upper product: 0x1000 * 0x0100
    applyStimulus(2'b10, 3'd0, 16'h1000, 7'd0);
    applyStimulus(2'b11, 3'd2, 16'h0100, 7'd0);
    idleInputs();
    countBusy(cyc);
    checkOutput("mulovf_ac",  32'(dut_if.ac_to_bus), 32'h0);
    checkOutput("mulovf_z",   32'(dut_if.z_flag),    32'h1);
    checkOutput("mulovf_ovf", 32'(dut_if.ovf),       32'(OVF_EN));

    // Reset in the middle of a MUL
    applyStimulus(2'b10, 3'd0, 16'd300, 7'd0);
    applyStimulus(2'b11, 3'd2, 16'd0, 7'd7);
    idleInputs();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ac",   32'(dut_if.ac_to_bus), 32'h0);
    checkOutput("midrst_busy", 32'(dut_if.busy),      32'h0);
    checkOutput("midrst_z",    32'(dut_if.z_flag),    32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b10, 3'd0, 16'd77, 7'd0);
    checkOutput("postrst_load", 32'(dut_if.ac_to_bus), 32'd77);
    checkOutput("postrst_busy", 32'(dut_if.busy),      32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
